// File: rtl/ws2812_pkg.sv
// Shared types and defaults for the WS2812 frame buffer: channel structs,
// read-FSM encoding and the RGB->GRB reorder used on the fetch path.
package ws2812_pkg;

  localparam int DEF_W_ADDR   = 6;
  localparam int DEF_NUM_LEDS = 64;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_SCALE = 2'd2,
    RD_DONE  = 2'd3
  } rd_state_t;

  function automatic grb_t rgb2grb(input rgb_t c);
    grb_t o;
    o.g = c.g;
    o.r = c.r;
    o.b = c.b;
    return o;
  endfunction

endpackage

// File: rtl/ws2812_scale8.sv
// Registered brightness stage: each channel becomes (c*(brightness+1))>>8,
// reordered to GRB and held until the next load.
module ws2812_scale8
  import ws2812_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  rgb_t       pixel,
  input  logic [7:0] brightness,
  output grb_t       scaled
);

  rgb_t scaled_rgb;

  // brightness+1 makes 255 an exact identity and 0 a hard black.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

  always_comb begin
    scaled_rgb   = '0;
    scaled_rgb.r = scale_ch(pixel.r, brightness);
    scaled_rgb.g = scale_ch(pixel.g, brightness);
    scaled_rgb.b = scale_ch(pixel.b, brightness);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scaled <= '0;
    end else if (load) begin
      scaled <= rgb2grb(scaled_rgb);
    end
  end

endmodule

// File: rtl/ws2812_frame_buf.sv
// Double-buffered WS2812 colour store: host writes the back bank, swaps only
// between frames, and the driver fetches scaled GRB pixels from the front bank.
module ws2812_frame_buf
  import ws2812_pkg::*;
#(
  parameter int W_ADDR   = DEF_W_ADDR,
  parameter int NUM_LEDS = DEF_NUM_LEDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [W_ADDR-1:0] wr_addr,
  input  logic [23:0]       wr_rgb,
  input  logic              swap_req,
  output logic              swap_done,
  input  logic [7:0]        brightness,
  input  logic              rd_start,
  input  logic [W_ADDR-1:0] rd_addr,
  output logic [23:0]       rd_data,
  output logic              rd_done,
  output logic [1:0]        dbg_state,
  output logic              dbg_bank_sel,
  output logic              dbg_swap_pending,
  output logic              dbg_frame_end
);

  localparam int DEPTH = 2 ** W_ADDR;
  localparam logic [W_ADDR:0] LED_LIMIT = (W_ADDR + 1)'(NUM_LEDS);
  localparam logic [W_ADDR:0] LED_LAST  = (W_ADDR + 1)'(NUM_LEDS - 1);

  rd_state_t         state, state_nxt;
  logic              rd_start_q, rd_edge;
  logic [W_ADDR-1:0] addr_q;
  logic              bank_sel, swap_pending, frame_end;
  logic              capture, scale_load, swap_go;
  logic              addr_in_range, wr_in_range;
  logic [23:0]       mem [2*DEPTH];
  rgb_t              ram_q, pixel;
  grb_t              scaled;

  assign rd_edge       = rd_start & ~rd_start_q;
  assign addr_in_range = {1'b0, addr_q} < LED_LIMIT;
  assign wr_in_range   = {1'b0, wr_addr} < LED_LIMIT;

  always_ff @(posedge clk) begin
    rd_start_q <= rd_start;
  end

  // Host writes go to the bank that is "back" before any swap this cycle.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[{~bank_sel, wr_addr}] <= wr_rgb;
    end
    if (state == RD_FETCH) begin
      ram_q <= mem[{bank_sel, addr_q}];
    end
  end

  // Fetch handshake: the driver raises rd_start with rd_addr valid and holds
  // both; rd_done stays high in DONE until rd_start drops, and dropping
  // rd_start before DONE abandons the fetch without touching rd_data.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    scale_load = 1'b0;
    swap_go    = 1'b0;
    case (state)
      RD_IDLE: begin
        if (rd_edge) begin
          capture   = 1'b1;
          state_nxt = RD_FETCH;
        end
        swap_go = swap_pending && frame_end && !rd_edge;
      end
      RD_FETCH: state_nxt = rd_start ? RD_SCALE : RD_IDLE;
      RD_SCALE: begin
        scale_load = rd_start;
        state_nxt  = rd_start ? RD_DONE : RD_IDLE;
      end
      RD_DONE:  if (!rd_start) state_nxt = RD_IDLE;
      default:  state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RD_IDLE;
      addr_q       <= '0;
      bank_sel     <= 1'b0;
      swap_pending <= 1'b0;
      frame_end    <= 1'b1;
      swap_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      swap_done <= swap_go;
      if (capture) begin
        addr_q <= rd_addr;
      end
      // A request coinciding with the swap itself is absorbed.
      if (swap_go) begin
        bank_sel     <= ~bank_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
      if (capture && rd_addr == '0) begin
        frame_end <= 1'b0;
      end else if (scale_load && {1'b0, addr_q} == LED_LAST) begin
        frame_end <= 1'b1;
      end
    end
  end

  assign pixel = addr_in_range ? ram_q : '0;

  ws2812_scale8 u_scale (
    .clk        (clk),
    .rst        (rst),
    .load       (scale_load),
    .pixel      (pixel),
    .brightness (brightness),
    .scaled     (scaled)
  );

  assign rd_data          = scaled;
  assign rd_done          = (state == RD_DONE);
  assign dbg_state        = state;
  assign dbg_bank_sel     = bank_sel;
  assign dbg_swap_pending = swap_pending;
  assign dbg_frame_end    = frame_end;

endmodule

// File: tb/tb_ws2812_frame_buf.sv
// Directed bench for ws2812_frame_buf: a vector table of pixel/brightness
// fetches plus hand-written swap, abort and reset sequences.
module tb_ws2812_frame_buf;

  localparam int W_ADDR   = 7;
  localparam int NUM_LEDS = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [W_ADDR-1:0] wr_addr;
  logic [23:0]       wr_rgb;
  logic              swap_req;
  logic              swap_done;
  logic [7:0]        brightness;
  logic              rd_start;
  logic [W_ADDR-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic              rd_done;
  logic [1:0]        dbg_state;
  logic              dbg_bank_sel;
  logic              dbg_swap_pending;
  logic              dbg_frame_end;

  ws2812_frame_buf #(.W_ADDR(W_ADDR), .NUM_LEDS(NUM_LEDS)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_rgb           (wr_rgb),
    .swap_req         (swap_req),
    .swap_done        (swap_done),
    .brightness       (brightness),
    .rd_start         (rd_start),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .rd_done          (rd_done),
    .dbg_state        (dbg_state),
    .dbg_bank_sel     (dbg_bank_sel),
    .dbg_swap_pending (dbg_swap_pending),
    .dbg_frame_end    (dbg_frame_end)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_bad    = 0;
  int swap_cnt = 0;

  always @(negedge clk) begin
    if (swap_done === 1'b1) swap_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W_ADDR-1:0] addr;
    logic [23:0]       rgb;
    logic [7:0]        bright;
    logic [23:0]       exp;
  } vec_t;

  vec_t vecs[8];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic write_px(input logic [W_ADDR-1:0] addr, input logic [23:0] rgb);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_rgb  = rgb;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic do_swap(output int cyc);
    pulse_swap();
    cyc = 1;
    do begin
      tick();
      cyc++;
    end while (swap_done !== 1'b1 && cyc < 10);
  endtask

  task automatic fetch(input logic [W_ADDR-1:0] addr, input logic [7:0] br,
                       output logic [23:0] data, output int lat);
    rd_addr    = addr;
    brightness = br;
    rd_start   = 1'b1;
    lat        = 0;
    do begin
      tick();
      lat++;
    end while (rd_done !== 1'b1 && lat < 10);
    data     = rd_data;
    rd_start = 1'b0;
    tick();
  endtask

  logic [23:0] data;
  int          lat, cyc, c0;
  logic        done_seen;

  initial begin
    vecs[0] = '{addr: 7'd5,  rgb: 24'h102030, bright: 8'd255, exp: 24'h201030};
    vecs[1] = '{addr: 7'd6,  rgb: 24'hFF8001, bright: 8'd127, exp: 24'h407F00};
    vecs[2] = '{addr: 7'd7,  rgb: 24'hFF8001, bright: 8'd0,   exp: 24'h000000};
    vecs[3] = '{addr: 7'd8,  rgb: 24'h123456, bright: 8'd255, exp: 24'h341256};
    vecs[4] = '{addr: 7'd9,  rgb: 24'h808080, bright: 8'd63,  exp: 24'h202020};
    vecs[5] = '{addr: 7'd63, rgb: 24'hFFFFFF, bright: 8'd254, exp: 24'hFEFEFE};
    vecs[6] = '{addr: 7'd70, rgb: 24'hFFFFFF, bright: 8'd255, exp: 24'h000000};
    vecs[7] = '{addr: 7'd10, rgb: 24'h0A0B0C, bright: 8'd128, exp: 24'h050506};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_rgb = '0; swap_req = 1'b0;
    brightness = 8'd0; rd_start = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check("rst_rd_data",   rd_data, 24'h0);
    check("rst_rd_done",   24'(rd_done), 24'h0);
    check("rst_swap_done", 24'(swap_done), 24'h0);
    check("rst_bank_sel",  24'(dbg_bank_sel), 24'h0);
    check("rst_pending",   24'(dbg_swap_pending), 24'h0);
    check("rst_frame_end", 24'(dbg_frame_end), 24'h1);
    check("rst_state",     24'(dbg_state), 24'h0);
    rst = 1'b0;
    tick();

    // Fill the back bank, swap it to the front, then run the vector table.
    write_px(7'd0, 24'h010203);
    for (int i = 0; i < 8; i++) write_px(vecs[i].addr, vecs[i].rgb);
    do_swap(cyc);
    check("swap1_latency", 24'(cyc), 24'd2);
    check("swap1_bank_sel", 24'(dbg_bank_sel), 24'h1);
    for (int i = 0; i < 8; i++) begin
      fetch(vecs[i].addr, vecs[i].bright, data, lat);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 24'(lat), 24'd3);
    end

    // Mid-frame: back-bank write and swap request stay invisible until frame end.
    write_px(7'd5, 24'hAABBCC);
    c0 = swap_cnt;
    fetch(7'd0, 8'd255, data, lat);
    check("frame_addr0", data, 24'h020103);
    pulse_swap();
    pulse_swap();
    check("pending_set", 24'(dbg_swap_pending), 24'h1);
    fetch(7'd5, 8'd255, data, lat);
    check("old_front_data", data, 24'h201030);
    check("no_swap_midframe", 24'(swap_cnt), 24'(c0));
    rd_addr = 7'd63; brightness = 8'd255; rd_start = 1'b1; lat = 0;
    do begin
      tick();
      lat++;
    end while (rd_done !== 1'b1 && lat < 10);
    check("last_led_data", rd_data, 24'hFFFFFF);
    repeat (3) tick();
    check("swap_held_in_done", 24'(swap_cnt), 24'(c0));
    rd_start = 1'b0;
    repeat (4) tick();
    check("swap_once_after_frame", 24'(swap_cnt), 24'(c0 + 1));
    check("swap2_bank_sel", 24'(dbg_bank_sel), 24'h0);
    fetch(7'd5, 8'd255, data, lat);
    check("new_front_data", data, 24'hBBAACC);

    // Abort during FETCH: no done, data held.
    rd_addr = 7'd6; brightness = 8'd255; rd_start = 1'b1;
    tick();
    rd_start  = 1'b0;
    done_seen = 1'b0;
    repeat (5) begin
      tick();
      if (rd_done === 1'b1) done_seen = 1'b1;
    end
    check("abort_no_done", 24'(done_seen), 24'h0);
    check("abort_data_held", rd_data, 24'hBBAACC);

    // Reset in SCALE with a swap pending.
    do_swap(cyc);
    check("swap3_bank_sel", 24'(dbg_bank_sel), 24'h1);
    fetch(7'd0, 8'd255, data, lat);
    pulse_swap();
    check("pending_before_rst", 24'(dbg_swap_pending), 24'h1);
    rd_addr = 7'd5; brightness = 8'd255; rd_start = 1'b1;
    tick();
    tick();
    check("in_scale", 24'(dbg_state), 24'd2);
    rst = 1'b1;
    tick();
    check("midrst_rd_done",  24'(rd_done), 24'h0);
    check("midrst_rd_data",  rd_data, 24'h0);
    check("midrst_bank_sel", 24'(dbg_bank_sel), 24'h0);
    check("midrst_pending",  24'(dbg_swap_pending), 24'h0);
    rst      = 1'b0;
    rd_start = 1'b0;
    c0       = swap_cnt;
    repeat (5) tick();
    check("no_swap_after_rst", 24'(swap_cnt), 24'(c0));
    fetch(7'd5, 8'd255, data, lat);
    check("post_rst_front_bank0", data, 24'hBBAACC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
